// File: rtl/airi5c_ram_arb_pkg.sv
// Shared constants and types for the two-requester RAM port arbiter.
// Requester ids double as grant indices and as the low bit of the lock owner code.
package airi5c_ram_arb_pkg;

  localparam logic REQ_IMEM = 1'b0;
  localparam logic REQ_DMEM = 1'b1;

  typedef enum logic [1:0] {
    LOCK_IMEM = 2'd0,
    LOCK_DMEM = 2'd1,
    LOCK_NONE = 2'd2
  } lockOwnerE;

  localparam int unsigned DEFAULT_NWORDS       = 65536;
  localparam int unsigned DEFAULT_ADDR_SHIFT   = 5;
  localparam int unsigned DEFAULT_LOCK_TIMEOUT = 16;

  function automatic lockOwnerE lockOf(input logic id);
    return id ? LOCK_DMEM : LOCK_IMEM;
  endfunction

endpackage

// File: rtl/airi5c_rr_picker.sv
// Two-way round-robin grant; a held lock restricts eligibility to its owner.
module airi5c_rr_picker (
  input  logic       enable_i,
  input  logic [1:0] valid_i,
  input  logic       rrPtr_i,
  input  logic       lockValid_i,
  input  logic       lockId_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    if (enable_i) begin
      if (lockValid_i) begin
        grant_o[lockId_i] = valid_i[lockId_i];
      end else if (&valid_i) begin
        grant_o[rrPtr_i] = 1'b1;
      end else begin
        grant_o = valid_i;
      end
    end
  end

endmodule

// File: rtl/airi5c_ram_arbiter.sv
// Shares one RAM port between instruction fetch (m0) and data (m1) requesters,
// tracking the one-cycle read latency, round-robin fairness and atomic locks.
module airi5c_ram_arbiter
  import airi5c_ram_arb_pkg::*;
#(
  parameter int unsigned NWORDS       = DEFAULT_NWORDS,
  parameter int unsigned ADDR_SHIFT   = DEFAULT_ADDR_SHIFT,
  parameter int unsigned LOCK_TIMEOUT = DEFAULT_LOCK_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic [31:0] m0_req_addr,
  input  logic [3:0]  m0_req_wstrb,
  input  logic [31:0] m0_req_wdata,
  input  logic        m0_req_lock,
  output logic        m0_rsp_valid,
  output logic [31:0] m0_rsp_rdata,
  output logic        m0_rsp_err,
  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic [31:0] m1_req_addr,
  input  logic [3:0]  m1_req_wstrb,
  input  logic [31:0] m1_req_wdata,
  input  logic        m1_req_lock,
  output logic        m1_rsp_valid,
  output logic [31:0] m1_rsp_rdata,
  output logic        m1_rsp_err,
  output logic        lock_abort,
  output logic        ram_en,
  output logic [3:0]  ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_di,
  input  logic [31:0] ram_do
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(LOCK_TIMEOUT - 1);

  lockOwnerE   lockOwner_q, lockOwner_d;
  logic        rrPtr_q, rrPtr_d;
  logic [7:0]  idleCnt_q, idleCnt_d;
  logic        pendValid_q, pendId_q, pendErr_q;

  logic [1:0]  reqValid, grant;
  logic        handshake, grantId, inRange, lockValid, ownerValid, lockAbort, rspLive;
  logic        selLock;
  logic [31:0] selAddr, selWdata, wordIdx;
  logic [3:0]  selWstrb;
  logic [1:0]  unusedAddrBits;

  assign reqValid  = {m1_req_valid, m0_req_valid};
  assign lockValid = (lockOwner_q != LOCK_NONE);

  // Grants are suppressed while reset is held so nothing reaches the RAM.
  airi5c_rr_picker u_picker (
    .enable_i    (!reset),
    .valid_i     (reqValid),
    .rrPtr_i     (rrPtr_q),
    .lockValid_i (lockValid),
    .lockId_i    (lockOwner_q[0]),
    .grant_o     (grant)
  );

  assign m0_req_ready = grant[0];
  assign m1_req_ready = grant[1];
  assign handshake    = |grant;
  assign grantId      = grant[1];

  assign selAddr        = grantId ? m1_req_addr  : m0_req_addr;
  assign selWdata       = grantId ? m1_req_wdata : m0_req_wdata;
  assign selWstrb       = grantId ? m1_req_wstrb : m0_req_wstrb;
  assign selLock        = grantId ? m1_req_lock  : m0_req_lock;
  assign unusedAddrBits = selAddr[1:0];

  assign wordIdx  = {2'b00, selAddr[31:2]};
  assign inRange  = (wordIdx < NWORDS);
  assign ram_en   = handshake & inRange;
  assign ram_we   = ram_en ? selWstrb : 4'b0000;
  assign ram_addr = wordIdx << ADDR_SHIFT;
  assign ram_di   = selWdata;

  // An owner raising valid on the deadline cycle is granted instead of aborted.
  assign ownerValid = reqValid[lockOwner_q[0]];
  assign lockAbort  = !reset & lockValid & !ownerValid & (idleCnt_q == TIMEOUT_LAST);
  assign lock_abort = lockAbort;

  always_comb begin
    rrPtr_d     = rrPtr_q;
    lockOwner_d = lockOwner_q;
    idleCnt_d   = idleCnt_q;
    if (handshake) begin
      rrPtr_d     = ~grantId;
      lockOwner_d = selLock ? lockOf(grantId) : LOCK_NONE;
      idleCnt_d   = 8'd0;
    end else if (lockAbort) begin
      lockOwner_d = LOCK_NONE;
      idleCnt_d   = 8'd0;
    end else if (lockValid) begin
      idleCnt_d   = idleCnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rrPtr_q     <= REQ_IMEM;
      lockOwner_q <= LOCK_NONE;
      idleCnt_q   <= 8'd0;
      pendValid_q <= 1'b0;
      pendId_q    <= REQ_IMEM;
      pendErr_q   <= 1'b0;
    end else begin
      rrPtr_q     <= rrPtr_d;
      lockOwner_q <= lockOwner_d;
      idleCnt_q   <= idleCnt_d;
      pendValid_q <= handshake;
      pendId_q    <= grantId;
      pendErr_q   <= !inRange;
    end
  end

  assign rspLive      = pendValid_q & !reset;
  assign m0_rsp_valid = rspLive & (pendId_q == REQ_IMEM);
  assign m1_rsp_valid = rspLive & (pendId_q == REQ_DMEM);
  assign m0_rsp_err   = m0_rsp_valid & pendErr_q;
  assign m1_rsp_err   = m1_rsp_valid & pendErr_q;
  assign m0_rsp_rdata = (m0_rsp_valid & !pendErr_q) ? ram_do : 32'h0;
  assign m1_rsp_rdata = (m1_rsp_valid & !pendErr_q) ? ram_do : 32'h0;

endmodule

// File: tb/tb_airi5c_ram_arbiter.sv
// Bench for airi5c_ram_arbiter: a write-first RAM emulator, a transaction-level
// reference model checked every cycle, directed scenarios and a random phase.
module tb_airi5c_ram_arbiter;

  localparam int unsigned NWORDS       = 65536;
  localparam int unsigned ADDR_SHIFT   = 5;
  localparam int unsigned LOCK_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req_valid, m0_req_ready, m0_req_lock, m0_rsp_valid, m0_rsp_err;
  logic [31:0] m0_req_addr, m0_req_wdata, m0_rsp_rdata;
  logic [3:0]  m0_req_wstrb;
  logic        m1_req_valid, m1_req_ready, m1_req_lock, m1_rsp_valid, m1_rsp_err;
  logic [31:0] m1_req_addr, m1_req_wdata, m1_rsp_rdata;
  logic [3:0]  m1_req_wstrb;
  logic        lock_abort, ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr, ram_di, ram_do;

  int errors = 0;
  int checks = 0;

  airi5c_ram_arbiter #(
    .NWORDS(NWORDS), .ADDR_SHIFT(ADDR_SHIFT), .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_addr(m0_req_addr),
    .m0_req_wstrb(m0_req_wstrb), .m0_req_wdata(m0_req_wdata), .m0_req_lock(m0_req_lock),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata), .m0_rsp_err(m0_rsp_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_addr(m1_req_addr),
    .m1_req_wstrb(m1_req_wstrb), .m1_req_wdata(m1_req_wdata), .m1_req_lock(m1_req_lock),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata), .m1_rsp_err(m1_rsp_err),
    .lock_abort(lock_abort), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_di(ram_di), .ram_do(ram_do)
  );

  always #5 clk = ~clk;

  // Two independent memories: one behind the RAM pins, one owned by the model.
  logic [31:0] ramMem  [logic [31:0]];
  logic [31:0] goldMem [logic [31:0]];

  function automatic logic [31:0] initVal(input logic [31:0] idx);
    return (idx * 32'h9E3779B1) ^ 32'hA5A50000;
  endfunction

  function automatic logic [31:0] ramRead(input logic [31:0] idx);
    return ramMem.exists(idx) ? ramMem[idx] : initVal(idx);
  endfunction

  function automatic logic [31:0] goldRead(input logic [31:0] idx);
    return goldMem.exists(idx) ? goldMem[idx] : initVal(idx);
  endfunction

  function automatic logic [31:0] mergeWord(input logic [31:0] old, input logic [31:0] nw,
                                            input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic setWord(input logic [31:0] idx, input logic [31:0] val);
    ramMem[idx]  = val;
    goldMem[idx] = val;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Write-first RAM port: the read data of a write cycle is the merged word.
  always @(posedge clk) begin : ramEmu
    logic [31:0] idx, w;
    if (ram_en) begin
      idx = ram_addr >> ADDR_SHIFT;
      w   = mergeWord(ramRead(idx), ram_di, ram_we);
      ramMem[idx] = w;
      ram_do <= w;
    end else begin
      ram_do <= $urandom;
    end
  end

  // Reference model state: round-robin pointer, lock owner (-1 = none),
  // idle cycles of the owner, and the response expected next cycle.
  bit          mInit = 0;
  int          mRr, mOwner, mIdle;
  bit          mPendValid, mPendErr;
  int          mPendId;
  logic [31:0] mPendData;

  always @(negedge clk) begin : modelCompare
    int          g;
    logic [1:0]  v;
    logic [31:0] a, wd, idx, w;
    logic [3:0]  s;
    logic        lk, inr, expAbort, expEn, rv0, rv1;
    v = {m1_req_valid, m0_req_valid};
    g = -1;
    a = m0_req_addr; wd = m0_req_wdata; s = m0_req_wstrb; lk = m0_req_lock;
    expAbort = 1'b0;
    if (mInit && !reset) begin
      if (mOwner >= 0) begin
        if (v[mOwner]) g = mOwner;
        else expAbort = (mIdle + 1 == int'(LOCK_TIMEOUT));
      end else if (v == 2'b11) g = mRr;
      else if (v[0]) g = 0;
      else if (v[1]) g = 1;
    end
    if (g == 1) begin
      a = m1_req_addr; wd = m1_req_wdata; s = m1_req_wstrb; lk = m1_req_lock;
    end
    idx   = a >> 2;
    inr   = (idx < NWORDS);
    expEn = (g >= 0) && inr;
    rv0   = !reset && mPendValid && (mPendId == 0);
    rv1   = !reset && mPendValid && (mPendId == 1);
    if (mInit) begin
      checkOutput("m0_req_ready", m0_req_ready, g == 0);
      checkOutput("m1_req_ready", m1_req_ready, g == 1);
      checkOutput("ram_en", ram_en, expEn);
      checkOutput("ram_we", ram_we, expEn ? s : 4'h0);
      if (g >= 0) begin
        checkOutput("ram_addr", ram_addr, idx << ADDR_SHIFT);
        checkOutput("ram_di", ram_di, wd);
      end
      checkOutput("lock_abort", lock_abort, expAbort);
      checkOutput("m0_rsp_valid", m0_rsp_valid, rv0);
      checkOutput("m1_rsp_valid", m1_rsp_valid, rv1);
      checkOutput("m0_rsp_err", m0_rsp_err, rv0 && mPendErr);
      checkOutput("m1_rsp_err", m1_rsp_err, rv1 && mPendErr);
      checkOutput("m0_rsp_rdata", m0_rsp_rdata, (rv0 && !mPendErr) ? mPendData : 32'h0);
      checkOutput("m1_rsp_rdata", m1_rsp_rdata, (rv1 && !mPendErr) ? mPendData : 32'h0);
    end
    if (reset) begin
      mInit = 1; mRr = 0; mOwner = -1; mIdle = 0; mPendValid = 0;
    end else if (mInit) begin
      mPendValid = (g >= 0);
      if (g >= 0) begin
        mPendId  = g;
        mPendErr = !inr;
        mPendData = 32'h0;
        if (inr) begin
          w = mergeWord(goldRead(idx), wd, s);
          goldMem[idx] = w;
          mPendData = w;
        end
        mRr    = 1 - g;
        mOwner = lk ? g : -1;
        mIdle  = 0;
      end else if (mOwner >= 0) begin
        mIdle++;
        if (mIdle == int'(LOCK_TIMEOUT)) begin
          mOwner = -1;
          mIdle  = 0;
        end
      end
    end
  end

  task automatic applyStimulus(input int n, input logic v, input logic [31:0] a,
                               input logic [3:0] s, input logic [31:0] d, input logic l);
    if (n == 0) begin
      m0_req_valid = v; m0_req_addr = a; m0_req_wstrb = s; m0_req_wdata = d; m0_req_lock = l;
    end else begin
      m1_req_valid = v; m1_req_addr = a; m1_req_wstrb = s; m1_req_wdata = d; m1_req_lock = l;
    end
  endtask

  task automatic idleAll();
    applyStimulus(0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    applyStimulus(1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic randomReq(input int n, input int pct);
    logic [31:0] a;
    int          r;
    r = int'($urandom_range(0, 15));
    if (r == 0)      a = (NWORDS + $urandom_range(0, 3)) << 2;
    else if (r == 1) a = 32'hFFFFFFFC;
    else             a = $urandom_range(0, 31) << 2;
    a[1:0] = 2'($urandom_range(0, 3));
    applyStimulus(n, int'($urandom_range(0, 99)) < pct, a,
                  ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15)),
                  $urandom, $urandom_range(0, 3) == 0);
  endtask

  task automatic startCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    int pct;
    pct = 50;
    setWord(32'h10, 32'hCAFE0010);
    setWord(32'h20, 32'hCAFE0020);
    setWord(32'h30, 32'h11223344);
    reset = 1'b1;
    idleAll();
    repeat (3) startCycle();
    settle();
    checkOutput("reset_rsp_valid", {m1_rsp_valid, m0_rsp_valid}, 2'b00);
    checkOutput("reset_lock_abort", lock_abort, 1'b0);
    startCycle(); reset = 1'b0;
    settle();
    checkOutput("post_reset_rsp_valid", {m1_rsp_valid, m0_rsp_valid}, 2'b00);
    checkOutput("post_reset_rdata", m0_rsp_rdata | m1_rsp_rdata, 32'h0);

    // Contest straight after reset: m0 first, then m1.
    startCycle();
    applyStimulus(0, 1'b1, 32'h40, 4'h0, 32'h0, 1'b0);
    applyStimulus(1, 1'b1, 32'h80, 4'h0, 32'h0, 1'b0);
    settle();
    checkOutput("contest_ready", {m1_req_ready, m0_req_ready}, 2'b01);
    checkOutput("contest_addr0", ram_addr, 32'h200);
    startCycle(); applyStimulus(0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    settle();
    checkOutput("contest_ready1", m1_req_ready, 1'b1);
    checkOutput("contest_addr1", ram_addr, 32'h400);
    checkOutput("contest_rsp0", m0_rsp_rdata, 32'hCAFE0010);
    startCycle(); applyStimulus(1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    settle();
    checkOutput("contest_rsp1", m1_rsp_rdata, 32'hCAFE0020);
    checkOutput("contest_rsp0_quiet", m0_rsp_valid, 1'b0);

    // Partial write then readback by the other requester.
    startCycle(); applyStimulus(1, 1'b1, 32'hC0, 4'b0101, 32'hAABBCCDD, 1'b0);
    settle();
    checkOutput("pwrite_we", ram_we, 4'b0101);
    startCycle();
    applyStimulus(1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 32'hC2, 4'h0, 32'h0, 1'b0);
    settle();
    checkOutput("pwrite_rsp1", m1_rsp_rdata, 32'h11BB33DD);
    startCycle(); applyStimulus(0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    settle();
    checkOutput("pwrite_readback0", m0_rsp_rdata, 32'h11BB33DD);

    // Out-of-range read.
    startCycle(); applyStimulus(0, 1'b1, NWORDS * 4, 4'h0, 32'h0, 1'b0);
    settle();
    checkOutput("oor_ready", m0_req_ready, 1'b1);
    checkOutput("oor_ram_en", ram_en, 1'b0);
    startCycle(); applyStimulus(0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    settle();
    checkOutput("oor_err", {m0_rsp_valid, m0_rsp_err}, 2'b11);
    checkOutput("oor_rdata", m0_rsp_rdata, 32'h0);

    // m1 locks; m0 starves until the unlocking write.
    startCycle();
    applyStimulus(1, 1'b1, 32'h40, 4'h0, 32'h0, 1'b1);
    applyStimulus(0, 1'b1, 32'h80, 4'h0, 32'h0, 1'b0);
    settle();
    checkOutput("lock_take", {m1_req_ready, m0_req_ready}, 2'b10);
    for (int i = 0; i < 4; i++) begin
      startCycle(); applyStimulus(1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
      settle();
      checkOutput("lock_starve", m0_req_ready, 1'b0);
    end
    startCycle(); applyStimulus(1, 1'b1, 32'h44, 4'hF, 32'h12345678, 1'b0);
    settle();
    checkOutput("lock_release", {m1_req_ready, m0_req_ready}, 2'b10);
    startCycle(); applyStimulus(1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    settle();
    checkOutput("lock_after", m0_req_ready, 1'b1);
    startCycle(); idleAll();

    // Lock timeout after 16 idle owner cycles.
    startCycle(); applyStimulus(1, 1'b1, 32'h48, 4'h0, 32'h0, 1'b1);
    settle();
    checkOutput("tmo_take", m1_req_ready, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      startCycle();
      applyStimulus(1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
      applyStimulus(0, 1'b1, 32'h80, 4'h0, 32'h0, 1'b0);
      settle();
      checkOutput("tmo_abort", lock_abort, i == 16);
      checkOutput("tmo_starve", m0_req_ready, 1'b0);
    end
    startCycle();
    settle();
    checkOutput("tmo_grant", {lock_abort, m0_req_ready}, 2'b01);
    startCycle(); idleAll();

    // Owner returning on the deadline cycle keeps its grant.
    startCycle(); applyStimulus(1, 1'b1, 32'h48, 4'h0, 32'h0, 1'b1);
    settle();
    for (int i = 1; i <= 15; i++) begin
      startCycle();
      applyStimulus(1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
      applyStimulus(0, 1'b1, 32'h80, 4'h0, 32'h0, 1'b0);
      settle();
    end
    startCycle(); applyStimulus(1, 1'b1, 32'h4C, 4'hF, 32'h5A5A5A5A, 1'b0);
    settle();
    checkOutput("deadline_owner", {lock_abort, m1_req_ready, m0_req_ready}, 3'b010);
    startCycle(); applyStimulus(1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    settle();
    checkOutput("deadline_next", m0_req_ready, 1'b1);
    startCycle(); idleAll();

    // Reset the cycle after a locked grant.
    startCycle(); applyStimulus(1, 1'b1, 32'h40, 4'h0, 32'h0, 1'b1);
    settle();
    checkOutput("rst_grant", m1_req_ready, 1'b1);
    startCycle(); applyStimulus(1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0); reset = 1'b1;
    settle();
    checkOutput("rst_drop", m1_rsp_valid, 1'b0);
    startCycle();
    reset = 1'b0;
    applyStimulus(0, 1'b1, 32'h80, 4'h0, 32'h0, 1'b0);
    applyStimulus(1, 1'b1, 32'h84, 4'h0, 32'h0, 1'b0);
    settle();
    checkOutput("rst_after", {m1_rsp_valid, m1_req_ready, m0_req_ready}, 3'b001);
    startCycle(); idleAll();

    // Random traffic with varying request density.
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) begin
        case ($urandom_range(0, 2))
          0:       pct = 10;
          1:       pct = 50;
          default: pct = 90;
        endcase
      end
      startCycle();
      reset = ($urandom_range(0, 399) == 0);
      if (reset) idleAll();
      else begin
        randomReq(0, pct);
        randomReq(1, pct);
      end
    end
    startCycle(); reset = 1'b0; idleAll();
    repeat (2) startCycle();
    settle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
